// File: rtl/mm_pkg.sv
// Shared minifloat definitions and feeder state encoding for the systolic matmul datapath.
// Operands are 8-bit minifloats: 1 sign bit, 3 exponent bits, 4 fraction bits.
package mm_pkg;

    localparam int DW    = 8;
    localparam int SIGN  = 1;
    localparam int EXP   = 3;
    localparam int FRACT = 4;

    // All-zero encoding; mac_unit treats it as a zero operand, so padding adds nothing.
    localparam logic [DW-1:0] ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One edge lane of the operand feeder: picks element (t - lane) of its buffer row/column,
// or ZERO when that index falls outside the matrix (leading/trailing skew padding).
module skew_lane #(
    parameter int N  = 2,
    parameter int DW = mm_pkg::DW,
    parameter int TW = $clog2(2 * N)
) (
    input  logic [TW-1:0]   lane,
    input  logic [TW-1:0]   t,
    input  logic [N*DW-1:0] operands,
    output logic [DW-1:0]   operand
);
    import mm_pkg::*;

    logic [TW:0] k;

    always_comb begin
        k       = {1'b0, t} - {1'b0, lane};
        operand = DW'(ZERO);
        if ((t >= lane) && (k < (TW + 1)'(N))) begin
            operand = operands[k*DW +: DW];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the N x N mac_unit array: buffers A and B, then streams them with
// diagonal skew on the west/north edges, and holds busy through the array drain time.
module systolic_feeder #(
    parameter int N     = 2,
    parameter int DW    = mm_pkg::DW,
    parameter int DRAIN = 4 * N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 edge_valid,
    output logic [N*DW-1:0]      a_edge,
    output logic [N*DW-1:0]      b_edge,
    output logic                 done
);
    import mm_pkg::*;

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(2 * N);
    localparam int CW = $clog2(DRAIN + 1);
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

    feeder_state_t state, nxt_state;
    logic [TW-1:0] t, nxt_t;
    logic [CW-1:0] drain_cnt, nxt_drain;

    logic [DW-1:0] a_buf     [N][N];
    logic [DW-1:0] b_buf     [N][N];
    logic [DW-1:0] a_buf_nxt [N][N];
    logic [DW-1:0] b_buf_nxt [N][N];

    logic [N*DW-1:0] a_rows [N];
    logic [N*DW-1:0] b_cols [N];
    logic [N*DW-1:0] a_beat, b_beat;

    logic idx_ok, wr_ok;

    // Out-of-range indices only exist when N is not a power of two.
    generate
        if ((1 << IW) == N) begin : g_pow2
            assign idx_ok = 1'b1;
        end else begin : g_npow2
            assign idx_ok = (wr_row < IW'(N)) && (wr_col < IW'(N));
        end
    endgenerate

    assign wr_ok = wr_en && idx_ok && ((state == IDLE) || (state == DONE));

    // Beats are built from the post-write buffer so a write coinciding with start is seen at beat 0.
    always_comb begin
        a_buf_nxt = a_buf;
        b_buf_nxt = b_buf;
        if (wr_ok) begin
            if (wr_sel) begin
                b_buf_nxt[wr_row][wr_col] = wr_data;
            end else begin
                a_buf_nxt[wr_row][wr_col] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end
            end
        end else begin
            a_buf <= a_buf_nxt;
            b_buf <= b_buf_nxt;
        end
    end

    // Lane i of A walks row i; lane j of B walks column j.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_rows[i] = '0;
            b_cols[i] = '0;
            for (int k = 0; k < N; k++) begin
                a_rows[i][k*DW +: DW] = a_buf_nxt[i][k];
                b_cols[i][k*DW +: DW] = b_buf_nxt[k][i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(.N(N), .DW(DW), .TW(TW)) u_a_lane (
            .lane     (TW'(i)),
            .t        (nxt_t),
            .operands (a_rows[i]),
            .operand  (a_beat[i*DW +: DW])
        );
        skew_lane #(.N(N), .DW(DW), .TW(TW)) u_b_lane (
            .lane     (TW'(i)),
            .t        (nxt_t),
            .operands (b_cols[i]),
            .operand  (b_beat[i*DW +: DW])
        );
    end

    always_comb begin
        nxt_state = state;
        nxt_t     = t;
        nxt_drain = drain_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = STREAM;
                    nxt_t     = '0;
                end
            end
            STREAM: begin
                if (t == T_LAST) begin
                    nxt_state = mm_pkg::DRAIN;
                    nxt_drain = CW'(DRAIN - 1);
                end else begin
                    nxt_t = t + TW'(1);
                end
            end
            mm_pkg::DRAIN: begin
                if (drain_cnt == '0) begin
                    nxt_state = DONE;
                end else begin
                    nxt_drain = drain_cnt - CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    nxt_state = STREAM;
                    nxt_t     = '0;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Every output is decoded from next-state so it lines up with the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            t          <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            edge_valid <= 1'b0;
            done       <= 1'b0;
            a_edge     <= '0;
            b_edge     <= '0;
        end else begin
            state      <= nxt_state;
            t          <= nxt_t;
            drain_cnt  <= nxt_drain;
            busy       <= (nxt_state == STREAM) || (nxt_state == mm_pkg::DRAIN);
            edge_valid <= (nxt_state == STREAM);
            done       <= (nxt_state == DONE);
            a_edge     <= (nxt_state == STREAM) ? a_beat : '0;
            b_edge     <= (nxt_state == STREAM) ? b_beat : '0;
        end
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand feeder sitting directly upstream of the N x N mac_unit systolic array.
- Buffers one N x N matrix A (row operands, west edge) and one N x N matrix B (column operands, north edge) of 8-bit minifloats (1 sign, 3 exp, 4 fract).
- On start, streams the operands diagonally skewed so that A[i][k] and B[k][j] meet at PE(i,j).
- Pads with 0x00, which mac_unit treats as a zero operand and adds nothing. Tracks drain time and signals done.

Parameters:
- N, 2, matrix dimension (array is N x N PEs), legal range 2..8.
- DW, 8, operand width in bits.
- DRAIN, 4*N, extra cycles after the last beat that busy stays high, covering the two-register hop latency per mac_unit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_row  in  $clog2(N)  row index.
- wr_col  in  $clog2(N)  column index.
- wr_data  in  DW  operand.
- start  in  1  single-cycle request to begin streaming.
- busy  out  1  high from the first beat through the end of drain.
- edge_valid  out  1  high while beats are on a_edge/b_edge.
- a_edge  out  N*DW  slice i drives west input a of PE(i,0).
- b_edge  out  N*DW  slice j drives north input b of PE(0,j).
- done  out  1  one-cycle pulse when drain completes.

Behaviour:
- Reset (async assert, sync release): A/B buffers = 0; a_edge, b_edge, edge_valid, busy, done = 0; FSM = IDLE; beat counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Writes:
  - Accepted when wr_en = 1 and FSM = IDLE or DONE; the write lands on that clock edge.
  - Ignored while busy.
  - Indices >= N are ignored.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: start=1 -> STREAM; beat counter t=0.
  - STREAM: lasts exactly 2N-1 cycles, t = 0..2N-2. At t = 2N-2 -> DRAIN with drain counter = DRAIN-1.
  - DRAIN: counts down to 0, then -> DONE.
  - DONE: lasts exactly one cycle, done=1. Then -> IDLE, or -> STREAM if start=1 in that cycle.
- Beat contents, on the cycle after the edge that samples start, for beat t:
  - a_edge slice i = A[i][t-i] if 0 <= t-i < N, else 0x00.
  - b_edge slice j = B[t-j][j] if 0 <= t-j < N, else 0x00.
  - edge_valid = 1 for those 2N-1 cycles.
- Outside STREAM: a_edge = b_edge = 0 and edge_valid = 0, so the array keeps receiving zeros.
- busy = 1 during STREAM and DRAIN (2N-1+DRAIN cycles); 0 in IDLE and DONE.
- Boundary and simultaneous events:
  - start while busy: ignored, with no queueing.
  - start and wr_en in the same IDLE cycle: the write lands, and the first beat already uses the updated buffer.
  - Buffers are not cleared by done, so repeated start replays the same matrices.
  - rst_n low mid-stream: immediate return to reset values; a partial stream is abandoned and done is not pulsed.
- Arithmetic: index math only, unsigned, with widths sized to $clog2(2N).

Decomposition:
- Shared package mm_pkg:
  - DW, the field widths (SIGN=1, EXP=3, FRACT=4), the ZERO = 8'h00 constant.
  - Feeder state enum {IDLE, STREAM, DRAIN, DONE}.
- One natural sub-module: skew_lane, instantiated 2N times (N for A, N for B).
  - Inputs: lane index, t, and the buffer row/column.
  - Output: the selected operand or ZERO.
- The FSM and counters stay in systolic_feeder.

Test Plan:
- N=2, reset only -> all outputs 0. After rst_n release and 5 idle cycles: busy=0, done=0, a_edge=b_edge=0.
- Load A={31,32;33,34}h and B={41,42;43,44}h, then pulse start. Required beats:
  - Beat 0: a_edge={00,31}, b_edge={00,41}.
  - Beat 1: a_edge={33,32}, b_edge={42,43}.
  - Beat 2: a_edge={34,00}, b_edge={44,00}.
  - edge_valid=1 for exactly those 3 cycles.
- Same run timing: busy high 3+8=11 cycles; done pulses for 1 cycle on the following cycle; busy=0 in that cycle.
- Pulse start at beat 1 and write A[0][0]=7F while busy -> both ignored; the stream is unchanged; after done, A[0][0] still reads 31 on replay.
- Assert rst_n=0 at beat 1 -> outputs drop to 0 asynchronously before the next edge; no done pulse; buffers read 00 on a subsequent start.
- Start asserted in the DONE cycle -> the next cycle is beat 0 of a new stream, with contents identical to the first run.
